morse_decode_ctrl: RTL

MORSE_DECODE_CTRL -- requirements
Module: MORSE_DECODE_CTRL

---
 rtl/morse_decode_ctrl_pkg.sv | 17 +
 rtl/morse_unit_tick.sv | 31 +++
 rtl/morse_decode_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/morse_decode_ctrl_pkg.sv
// Shared character codes, widths and FSM state encoding for the Morse decode controller.
package morse_decode_ctrl_pkg;

  localparam int CHAR_W = 8;
  localparam logic [CHAR_W-1:0] CHAR_CODE_SPACE = 8'h20;
  localparam logic [CHAR_W-1:0] CHAR_CODE_ERR   = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_SPACE   = 3'd4,
    ST_ERR     = 3'd5
  } state_e;

endpackage

// File: rtl/morse_unit_tick.sv
// Morse time-unit prescaler: one-cycle tick every pulses_per_unit cycles while run is high.
// Combinational tick from the count register; counter parked at 0 whenever run is low.
module morse_unit_tick #(
  parameter int PPU_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [PPU_W-1:0] pulses_per_unit,
  output logic             tick
);

  logic [PPU_W-1:0] cnt_q, cnt_d, term;
  logic             at_term;

  // A zero period behaves as one: tick on every running cycle.
  assign term    = (pulses_per_unit == '0) ? '0 : pulses_per_unit - PPU_W'(1);
  assign at_term = (cnt_q >= term);
  assign tick    = run && at_term;

  always_comb begin
    cnt_d = '0;
    if (run && !at_term) cnt_d = cnt_q + PPU_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/morse_decode_ctrl.sv
// Morse decode controller: sequences the capture block, keeps a shift display, emits a char stream.
// Event sampled on cycle n -> out_valid on n+1; capture stalls (cap_ce=0) until out_ready accepts.
// Optional MORSE_DECODE_ERRMARK_EN: capture errors are emitted as CHAR_CODE_ERR instead of dropped.
module morse_decode_ctrl
  import morse_decode_ctrl_pkg::*;
#(
  parameter int PPU_W  = 16,
  parameter int DISP_N = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         flush,
  input  logic [PPU_W-1:0]             pulses_per_unit,
  input  logic                         cap_char_end,
  input  logic                         cap_word_end,
  input  logic                         cap_error,
  input  logic [CHAR_W-1:0]            rec_char,
  output logic                         cap_ce,
  output logic                         cap_clr,
  output logic [DISP_N*CHAR_W-1:0]     disp,
  output logic [$clog2(DISP_N+1)-1:0]  disp_cnt,
  output logic [CHAR_W-1:0]            out_char,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int CNT_W = $clog2(DISP_N+1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DISP_N);

  state_e                        state_q, state_d;
  logic                          space_pend_q, space_pend_d;
  logic                          out_valid_q, out_valid_d;
  logic [CHAR_W-1:0]             out_char_q;
  logic                          cap_clr_q;
  logic [DISP_N-1:0][CHAR_W-1:0] disp_q;
  logic [CNT_W-1:0]              disp_cnt_q;
  logic                          emit, space_ok, in_capture;
  logic [CHAR_W-1:0]             code;

  assign in_capture = (state_q == ST_CAPTURE);

  morse_unit_tick #(.PPU_W(PPU_W)) u_unit_tick (
    .clk             (clk),
    .rst_n           (rst_n),
    .run             (in_capture),
    .pulses_per_unit (pulses_per_unit),
    .tick            (cap_ce)
  );

  // Word gaps never lead the display and never repeat.
  assign space_ok = (disp_cnt_q != '0) && (disp_q[0] != CHAR_CODE_SPACE);

  always_comb begin
    state_d      = state_q;
    space_pend_d = space_pend_q;
    emit         = 1'b0;
    code         = rec_char;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (space_pend_q) begin
          state_d      = ST_SPACE;
          space_pend_d = 1'b0;
          emit         = space_ok;
          code         = CHAR_CODE_SPACE;
        end else if (en) state_d = ST_CAPTURE;
        else             state_d = ST_IDLE;
      end
      ST_CAPTURE: begin
        if (!en) state_d = ST_IDLE;
        else if (cap_error) begin
`ifdef MORSE_DECODE_ERRMARK_EN
          state_d = ST_ERR;
          emit    = 1'b1;
          code    = CHAR_CODE_ERR;
`else
          state_d = ST_CLEAR;
`endif
        end else if (cap_char_end) begin
          state_d      = ST_COMMIT;
          emit         = 1'b1;
          space_pend_d = cap_word_end;
        end else if (cap_word_end) begin
          state_d = ST_SPACE;
          emit    = space_ok;
          code    = CHAR_CODE_SPACE;
        end
      end
`ifdef MORSE_DECODE_ERRMARK_EN
      ST_COMMIT, ST_SPACE, ST_ERR: if (!out_valid_q || out_ready) state_d = ST_CLEAR;
`else
      ST_COMMIT, ST_SPACE:         if (!out_valid_q || out_ready) state_d = ST_CLEAR;
`endif
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = out_valid_q;
    if (emit)                          out_valid_d = 1'b1;
    else if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (flush) begin
      state_d      = en ? ST_CLEAR : ST_IDLE;
      space_pend_d = 1'b0;
      out_valid_d  = 1'b0;
      emit         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      space_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_char_q   <= '0;
      cap_clr_q    <= 1'b0;
      disp_q       <= {DISP_N{CHAR_CODE_SPACE}};
      disp_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      space_pend_q <= space_pend_d;
      out_valid_q  <= out_valid_d;
      cap_clr_q    <= (state_d == ST_CLEAR);
      if (flush) begin
        disp_q     <= {DISP_N{CHAR_CODE_SPACE}};
        disp_cnt_q <= '0;
      end else if (emit) begin
        disp_q     <= {disp_q[DISP_N-2:0], code};
        out_char_q <= code;
        if (disp_cnt_q != CNT_MAX) disp_cnt_q <= disp_cnt_q + CNT_W'(1);
      end
    end
  end

  assign cap_clr   = cap_clr_q;
  assign disp      = disp_q;
  assign disp_cnt  = disp_cnt_q;
  assign out_char  = out_char_q;
  assign out_valid = out_valid_q;

endmodule
